tx_slot_sequencer: RTL

TX_SLOT_SEQUENCER -- requirements
Module: tx_slot_sequencer

---
 rtl/tx_slot_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tx_slot_sequencer.sv
// tx_slot_sequencer: interleaves left/right source samples into a TxFIFO write port.
// Mono mode duplicates the left sample into the right slot.
// A right slot that stays idle too long is zero-filled and counted as an underrun.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | sequencing stopped, no handshakes, tx_data held at zero
// SLOT_L   | waiting for a left sample; frame boundary where en is honoured
// SLOT_R   | waiting for a right sample; timeout counter runs while FIFO has room
// SLOT_DUP | mono pair: writing the held left sample into the right slot
module tx_slot_sequencer #(
    parameter int DW          = 32,
    parameter int UNDERRUN_TO = 16,
    parameter int CNT_W       = 16
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             en,
    input  logic             mono,
    input  logic             l_valid,
    input  logic [DW-1:0]    l_data,
    output logic             l_ready,
    input  logic             r_valid,
    input  logic [DW-1:0]    r_data,
    output logic             r_ready,
    input  logic             tx_full,
    output logic             tx_wen,
    output logic [DW-1:0]    tx_data,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SLOT_L   = 2'd1,
        SLOT_R   = 2'd2,
        SLOT_DUP = 2'd3
    } state_t;

    // UNDERRUN_TO is limited to 1..255, so eight bits always hold the count.
    localparam logic [7:0] TO_LAST = 8'(UNDERRUN_TO - 1);

    state_t        state, state_nxt;
    logic [7:0]    to_cnt, to_cnt_nxt;
    logic [DW-1:0] hold_q;
    logic          cap_hold;
    logic          frame_inc;
    logic          under_inc;

    assign busy = (state != IDLE);

    // Next-state, handshake and FIFO write decode; reset masks every handshake.
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        l_ready    = 1'b0;
        r_ready    = 1'b0;
        tx_wen     = 1'b0;
        tx_data    = '0;
        cap_hold   = 1'b0;
        frame_inc  = 1'b0;
        under_inc  = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = SLOT_L;
                end
            end
            SLOT_L: begin
                l_ready = !tx_full;
                if (l_valid && !tx_full) begin
                    tx_wen     = 1'b1;
                    tx_data    = l_data;
                    to_cnt_nxt = '0;
                    // mono is only looked at here, so a pair never changes mode halfway
                    if (mono) begin
                        cap_hold  = 1'b1;
                        state_nxt = SLOT_DUP;
                    end else begin
                        state_nxt = SLOT_R;
                    end
                end else if (!en) begin
                    state_nxt = IDLE;
                end
            end
            SLOT_R: begin
                r_ready = !tx_full;
                if (!tx_full) begin
                    if (r_valid) begin
                        // a real sample wins even in the cycle the timeout would expire
                        tx_wen    = 1'b1;
                        tx_data   = r_data;
                        frame_inc = 1'b1;
                        state_nxt = SLOT_L;
                    end else if (to_cnt == TO_LAST) begin
                        tx_wen     = 1'b1;
                        tx_data    = '0;
                        frame_inc  = 1'b1;
                        under_inc  = 1'b1;
                        to_cnt_nxt = '0;
                        state_nxt  = SLOT_L;
                    end else begin
                        to_cnt_nxt = to_cnt + 8'd1;
                    end
                end
            end
            SLOT_DUP: begin
                if (!tx_full) begin
                    tx_wen    = 1'b1;
                    tx_data   = hold_q;
                    frame_inc = 1'b1;
                    state_nxt = SLOT_L;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (preset) begin
            l_ready = 1'b0;
            r_ready = 1'b0;
            tx_wen  = 1'b0;
        end
    end

    // State, timeout, hold register and status counters; reset drops any half-frame.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state        <= IDLE;
            to_cnt       <= '0;
            hold_q       <= '0;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (cap_hold) begin
                hold_q <= l_data;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (under_inc && (underrun_cnt != {CNT_W{1'b1}})) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule
